// File: rtl/sys_pkg.sv
// Shared widths and probe FSM encoding for the system top and debug probe.
// No ports; imported by sys_probe_* files.
package sys_pkg;

  localparam int LEDS_W = 27;
  localparam int PC_W   = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  localparam int BUF_DEPTH = 1 << SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } probe_state_t;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [LEDS_W-1:0] leds_t;
  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/sys_probe_ctrl_if.sv
// Readout valid/ready port of the probe controller.
// master: drives rd_valid/rd_sel/rd_data, samples rd_ready.
interface sys_probe_ctrl_if
  import sys_pkg::*;
();

  logic  rd_valid;
  logic  rd_ready;
  sel_t  rd_sel;
  leds_t rd_data;

  modport master (
    output rd_valid,
    output rd_sel,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_sel,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/sys_probe_buf.sv
// 8x27 capture buffer: sync write, async read, no storage reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module sys_probe_buf
  import sys_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  sel_t  waddr,
  input  leds_t wdata,
  input  sel_t  raddr,
  output leds_t rdata
);

  leds_t mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sys_probe_ctrl.sv
// Debug probe: optional PC load, selector scan, LED capture, readout.
// Ports: SYS_* system side, start/do_load/pc_val_in, busy/done, rd port.
module sys_probe_ctrl
  import sys_pkg::*;
#(
  parameter int SEL_COUNT     = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic  SYS_clk,
  input  logic  SYS_reset,
  input  logic  start,
  input  logic  do_load,
  input  pc_t   pc_val_in,
  output logic  SYS_load,
  output pc_t   SYS_pc_val,
  output sel_t  SYS_output_sel,
  input  leds_t SYS_leds,
  output logic  busy,
  output logic  done,
  sys_probe_ctrl_if.master rd
);

  localparam sel_t LAST_SEL   = SEL_W'(SEL_COUNT - 1);
  localparam cnt_t SETTLE_INI = CNT_W'(SETTLE_CYCLES);

  probe_state_t state_q;
  probe_state_t state_d;

  sel_t  sel_q;
  sel_t  idx_q;
  cnt_t  cnt_q;
  pc_t   pc_q;
  logic  done_q;

  logic  accept;
  logic  cap_we;
  logic  hs;
  logic  last_rd;
  logic  settle_in;
  leds_t buf_rd;

  assign accept  = (state_q == ST_IDLE) && start;
  assign cap_we  = (state_q == ST_CAPTURE);
  assign hs      = (state_q == ST_DRAIN) && rd.rd_ready;
  assign last_rd = (idx_q == LAST_SEL);

  // Counter reloads on every fresh entry into SETTLE.
  assign settle_in = (state_d == ST_SETTLE) &&
                     (state_q != ST_SETTLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = do_load ? ST_LOAD : ST_SETTLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= cnt_t'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (sel_q == LAST_SEL) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DRAIN: begin
        if (hs && last_rd) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hs && last_rd;

      if (accept) begin
        pc_q  <= pc_val_in;
        sel_q <= '0;
      end

      if (settle_in) begin
        cnt_q <= SETTLE_INI;
      end else if (state_q == ST_SETTLE) begin
        cnt_q <= cnt_q - cnt_t'(1);
      end

      // Selector holds at the last value through DRAIN/IDLE.
      if (cap_we) begin
        if (sel_q == LAST_SEL) begin
          idx_q <= '0;
        end else begin
          sel_q <= sel_q + sel_t'(1);
        end
      end

      // Index parks on the last entry rather than wrapping.
      if (hs && !last_rd) begin
        idx_q <= idx_q + sel_t'(1);
      end
    end
  end

  sys_probe_buf u_buf (
    .clk   (SYS_clk),
    .we    (cap_we),
    .waddr (sel_q),
    .wdata (SYS_leds),
    .raddr (idx_q),
    .rdata (buf_rd)
  );

  assign SYS_load       = (state_q == ST_LOAD);
  assign SYS_pc_val     = pc_q;
  assign SYS_output_sel = sel_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

  // Gated so stale buffer contents never show outside DRAIN.
  assign rd.rd_valid = (state_q == ST_DRAIN);
  assign rd.rd_sel   = idx_q;
  assign rd.rd_data  = rd.rd_valid ? buf_rd : '0;

endmodule

// File: doc/sys_probe_ctrl.md
# sys_probe_ctrl

Hardware debug controller that drives the system core's load/display interface and reads back its 27-bit LED word. On `start` it optionally pulses `SYS_load` with a PC value. It then steps `SYS_output_sel` through every display selector, waits a settle interval, and captures `SYS_leds` into an internal buffer. Captured words are streamed out over a valid/ready port. It sits between board switches or a host link and the system top, and replaces the stimulus a bench would otherwise apply by hand.

## Interface
- `SEL_COUNT`, default 8: number of selector values scanned (0..SEL_COUNT-1); legal range 1..8.
- `SETTLE_CYCLES`, default 2: cycles held on each selector before capture; legal range 1..15.
- `SYS_clk` in 1: single clock; all state updates on its rising edge.
- `SYS_reset` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `do_load` in 1: sampled with `start`; 1 means issue a PC load before scanning.
- `pc_val_in` in 8: PC value latched with `start`.
- `SYS_load` out 1: one-cycle load pulse to the system.
- `SYS_pc_val` out 8: latched PC value; stable from start acceptance until the next accepted start.
- `SYS_output_sel` out 3: display selector driven to the system.
- `SYS_leds` in 27: LED word returned by the system for the current selector.
- `busy` out 1: high in every state except IDLE.
- `rd_valid` out 1, `rd_ready` in 1: readout handshake.
- `rd_sel` out 3: selector index of the word on `rd_data`.
- `rd_data` out 27: captured LED word.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, LOAD, SETTLE, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 latches `pc_val_in` and clears the selector to 0.
  - Next state is LOAD if `do_load`=1, otherwise SETTLE.
- LOAD: `SYS_load`=1 for exactly one cycle, then SETTLE.
- SETTLE:
  - Counter loads SETTLE_CYCLES on entry and decrements each cycle.
  - Go to CAPTURE when the count reaches 1.
- CAPTURE (one cycle):
  - Write `SYS_leds` into buffer entry `SYS_output_sel`.
  - If sel = SEL_COUNT-1, clear the read index and go to DRAIN.
  - Otherwise increment sel and return to SETTLE.
- DRAIN:
  - `rd_valid`=1, `rd_sel`=read index, `rd_data`=buffer[read index].
  - On `rd_valid`&`rd_ready`: advance the index.
  - After the last index: pulse `done`, go to IDLE.
- `SYS_output_sel` changes only on leaving CAPTURE. It holds its last value in DRAIN and IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from `rd_ready` to `rd_valid`.

## Timing
- Reset values:
  - State IDLE.
  - `SYS_load`, `busy`, `rd_valid`, `done` = 0.
  - `SYS_output_sel` = 0, `SYS_pc_val` = 0, `rd_sel` = 0, `rd_data` = 0.
  - Buffer contents are not cleared; they are don't-care until rewritten.
- Per-word capture latency is SETTLE_CYCLES+1 cycles.
- Scan length from the start-accept edge to the first `rd_valid`=1 is (do_load ? 1 : 0) + SEL_COUNT·(SETTLE_CYCLES+1). Defaults: 25 cycles with load, 24 without.
- `SYS_leds` is sampled at the rising edge ending the CAPTURE cycle. At that point `SYS_output_sel` has been stable SETTLE_CYCLES+1 cycles.
- Drain: one word per cycle with `rd_ready` held high. Back-pressure holds `rd_data` and `rd_sel` stable.
- `done` is high in the cycle after the final handshake. `busy` falls in the same cycle.
- Boundary conditions:
  - `start` while busy is ignored; it is not queued.
  - `rd_ready` while `rd_valid`=0 is ignored.
  - `SYS_reset` takes priority over `start` in the same cycle.
  - `SYS_reset` mid-scan or mid-drain aborts to IDLE next edge, with no `done` pulse and no `SYS_load` pulse.
  - SEL_COUNT=1 goes SETTLE→CAPTURE→DRAIN with a single word.
  - Selector and read index never exceed SEL_COUNT-1; there is no wrap into unscanned entries.

## Structure
- Shared package `sys_pkg` holds the state encoding constants and the widths LEDS_W=27, PC_W=8, SEL_W=3. Widths are shared with the system top.
- Sub-module `sys_probe_buf`: an 8×27 register file with one synchronous write port (CAPTURE) and one asynchronous read port (DRAIN). No reset on storage.
- Settle counter width is 4 bits.

## Test plan
- Reset, then `start`=1, `do_load`=1, `pc_val_in`=0x14, defaults → `SYS_load` high exactly 1 cycle with `SYS_pc_val`=0x14; first `rd_valid` 25 cycles after accept.
- Model returns `SYS_leds` = {24'h0, sel} ^ 27'h5A5A5A5, `rd_ready`=1 → 8 consecutive words, `rd_sel` 0..7, data matching the model, `done` one cycle after the 8th.
- `do_load`=0 → `SYS_load` never asserts; first `rd_valid` at 24 cycles.
- Random `rd_ready` toggling in DRAIN → `rd_data`/`rd_sel` stable while stalled; no word lost or duplicated.
- `start` pulsed during SETTLE and during DRAIN → ignored; scan and word count unchanged.
- `SYS_reset` at the 4th CAPTURE → next cycle all outputs at reset values; a fresh `start` completes a full clean scan.
